// File: rtl/axis_register_writer_if.sv
// AXI-stream style beat channel (valid/ready/data/dest) feeding axis_register_writer.
interface axis_register_writer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEST_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [DEST_WIDTH-1:0] dest;

  modport master (output valid, output data, output dest, input  ready);
  modport slave  (input  valid, input  data, input  dest, output ready);
endinterface

// File: rtl/axis_register_writer.sv
// axis_register_writer: buffers incoming {dest,data} beats in a small FIFO, issues
// each as a valid/ready register write, mirrors committed writes into a shadow
// bank and pulses batch_done every BATCH_LENGTH commits.
// Optional feature: define AXIS_REGISTER_WRITER_RANGE_CHECK_EN to drop beats whose
// dest is outside the shadow bank at push time and flag them on a sticky range_error.
module axis_register_writer #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEST_WIDTH   = 8,
  parameter int unsigned N_REGISTERS  = 3,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned BATCH_LENGTH = 3
) (
  input  logic                            clock,
  input  logic                            reset,
  axis_register_writer_if.slave           data_in,
  output logic [DEST_WIDTH-1:0]           wr_addr,
  output logic [DATA_WIDTH-1:0]           wr_data,
  output logic                            wr_valid,
  input  logic                            wr_ready,
  output logic [N_REGISTERS*DATA_WIDTH-1:0] registers_out,
  output logic                            batch_done
`ifdef AXIS_REGISTER_WRITER_RANGE_CHECK_EN
  ,
  output logic                            range_error
`endif
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned BATCH_W = $clog2(BATCH_LENGTH + 1);
  // dest comparisons are done at least this wide so no dest bit is ever dropped
  localparam int unsigned CMP_W   = (DEST_WIDTH > 32) ? DEST_WIDTH : 32;

  logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_d [FIFO_DEPTH];
  logic [DEST_WIDTH-1:0] mem_dest_q [FIFO_DEPTH];
  logic [DEST_WIDTH-1:0] mem_dest_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] regs_q [N_REGISTERS];
  logic [DATA_WIDTH-1:0] regs_d [N_REGISTERS];
  logic [BATCH_W-1:0]    batch_cnt_q, batch_cnt_d;
  logic                  batch_done_q, batch_done_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic store;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = data_in.valid && !full;
  assign pop   = !empty && wr_ready;

`ifdef AXIS_REGISTER_WRITER_RANGE_CHECK_EN
  logic in_range_in;
  logic range_error_q, range_error_d;

  assign in_range_in = (CMP_W'(data_in.dest) < CMP_W'(N_REGISTERS));
  // Out-of-range beats are still handshaken but never enter the FIFO
  assign store       = push && in_range_in;
  assign range_error = range_error_q;
`else
  assign store = push;
`endif

  assign data_in.ready = !full;
  assign wr_valid      = !empty;
  assign wr_addr       = mem_dest_q[rd_ptr_q];
  assign wr_data       = mem_data_q[rd_ptr_q];
  assign batch_done    = batch_done_q;

  // Flatten the shadow bank onto the output bus, register i at slice i
  always_comb begin
    registers_out = '0;
    for (int i = 0; i < int'(N_REGISTERS); i++) begin
      registers_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

  // Next-state: FIFO push/pop, shadow bank update and batch counting
  always_comb begin
    mem_data_d   = mem_data_q;
    mem_dest_d   = mem_dest_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    regs_d       = regs_q;
    batch_cnt_d  = batch_cnt_q;
    batch_done_d = 1'b0;
    count_d      = count_q + CNT_W'(store) - CNT_W'(pop);

    if (store) begin
      mem_data_d[wr_ptr_q] = data_in.data;
      mem_dest_d[wr_ptr_q] = data_in.dest;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      // Out-of-range addresses match no slot and leave the bank untouched
      for (int i = 0; i < int'(N_REGISTERS); i++) begin
        if (CMP_W'(wr_addr) == CMP_W'(i)) begin
          regs_d[i] = wr_data;
        end
      end
      if (batch_cnt_q == BATCH_W'(BATCH_LENGTH - 1)) begin
        batch_cnt_d  = '0;
        batch_done_d = 1'b1;
      end else begin
        batch_cnt_d = batch_cnt_q + BATCH_W'(1);
      end
    end
  end

`ifdef AXIS_REGISTER_WRITER_RANGE_CHECK_EN
  // Sticky flag for any beat dropped because its dest misses the shadow bank
  always_comb begin
    range_error_d = range_error_q | (push && !in_range_in);
  end

  // range_error register, cleared only by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      range_error_q <= 1'b0;
    end else begin
      range_error_q <= range_error_d;
    end
  end
`endif

  // State registers; reset discards buffered beats and clears the bank asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_data_q[i] <= '0;
        mem_dest_q[i] <= '0;
      end
      for (int i = 0; i < int'(N_REGISTERS); i++) begin
        regs_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      batch_cnt_q  <= '0;
      batch_done_q <= 1'b0;
    end else begin
      mem_data_q   <= mem_data_d;
      mem_dest_q   <= mem_dest_d;
      regs_q       <= regs_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      batch_cnt_q  <= batch_cnt_d;
      batch_done_q <= batch_done_d;
    end
  end

endmodule

// File: tb/tb_axis_register_writer.sv
// Bench for axis_register_writer: directed scenarios plus a random phase, with a
// queue-based reference of accepted beats checked by a negedge monitor.
module tb_axis_register_writer;

  localparam int unsigned DW    = 32;
  localparam int unsigned TW    = 8;
  localparam int unsigned NREG  = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BATCH = 3;

  typedef struct {
    logic [TW-1:0] dest;
    logic [DW-1:0] data;
  } beat_t;

  logic                 clock;
  logic                 reset;
  logic [TW-1:0]        wr_addr;
  logic [DW-1:0]        wr_data;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [NREG*DW-1:0]   registers_out;
  logic                 batch_done;
`ifdef AXIS_REGISTER_WRITER_RANGE_CHECK_EN
  logic                 range_error;
`endif

  axis_register_writer_if #(.DATA_WIDTH(DW), .DEST_WIDTH(TW)) data_in ();

  axis_register_writer #(
    .DATA_WIDTH(DW), .DEST_WIDTH(TW), .N_REGISTERS(NREG),
    .FIFO_DEPTH(DEPTH), .BATCH_LENGTH(BATCH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .data_in(data_in),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .registers_out(registers_out),
    .batch_done(batch_done)
`ifdef AXIS_REGISTER_WRITER_RANGE_CHECK_EN
    ,
    .range_error(range_error)
`endif
  );

  // Reference state: beats accepted and expected on the write port, in order
  beat_t         exp_q [$];
  logic [DW-1:0] exp_regs [NREG];
  int            commits_in_batch = 0;
  bit            exp_bd = 1'b0;
  bit            exp_range_err = 1'b0;
  bit            rand_ready_en = 1'b0;
  int            n_checks = 0;
  int            n_pass = 0;
  int            n_bd_seen = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [NREG*DW-1:0] pack_regs();
    logic [NREG*DW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(NREG); i++) r[i*DW +: DW] = exp_regs[i];
    return r;
  endfunction

  function automatic bit dest_in_range(input logic [TW-1:0] d);
    return int'(d) < int'(NREG);
  endfunction

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < int'(NREG); i++) exp_regs[i] = '0;
    commits_in_batch = 0;
    exp_bd = 1'b0;
    exp_range_err = 1'b0;
  endtask

  // Record an accepted beat into the reference
  task automatic record(input logic [TW-1:0] d, input logic [DW-1:0] v);
    beat_t b;
    b.dest = d;
    b.data = v;
`ifdef AXIS_REGISTER_WRITER_RANGE_CHECK_EN
    if (!dest_in_range(d)) exp_range_err = 1'b1;
    else exp_q.push_back(b);
`else
    exp_q.push_back(b);
`endif
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Offer one beat (called at posedge+1); returns at posedge+1 after the accepting edge
  task automatic send_beat(input logic [TW-1:0] d, input logic [DW-1:0] v);
    int  waited;
    bit  done;
    waited = 0;
    done   = 1'b0;
    data_in.valid = 1'b1;
    data_in.dest  = d;
    data_in.data  = v;
    while (!done) begin
      @(negedge clock);
      if (data_in.ready) begin
        #1;
        record(d, v);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 200) begin
          check("accept_timeout", 1'b0, 1'b1);
          done = 1'b1;
        end
      end
    end
    @(posedge clock);
    #1;
    data_in.valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      cycles(1);
      n++;
    end
    check("drain_empty", 128'(exp_q.size()), 128'(0));
    cycles(2);
  endtask

  // Monitor: compare DUT state against the reference, then apply this cycle's commit
  always @(negedge clock) begin
    beat_t b;
    check("wr_valid", 128'(wr_valid), 128'(exp_q.size() != 0));
    check("in_ready", 128'(data_in.ready), 128'(exp_q.size() < int'(DEPTH)));
    if (wr_valid && exp_q.size() != 0) begin
      check("wr_addr", 128'(wr_addr), 128'(exp_q[0].dest));
      check("wr_data", 128'(wr_data), 128'(exp_q[0].data));
    end
    check("registers_out", 128'(registers_out), 128'(pack_regs()));
    check("batch_done", 128'(batch_done), 128'(exp_bd));
`ifdef AXIS_REGISTER_WRITER_RANGE_CHECK_EN
    check("range_error", 128'(range_error), 128'(exp_range_err));
`endif
    if (batch_done) n_bd_seen++;
    exp_bd = 1'b0;
    if (!reset && wr_valid && wr_ready && exp_q.size() != 0) begin
      b = exp_q.pop_front();
      if (dest_in_range(b.dest)) exp_regs[int'(b.dest)] = b.data;
      commits_in_batch++;
      if (commits_in_batch == int'(BATCH)) begin
        commits_in_batch = 0;
        exp_bd = 1'b1;
      end
    end
  end

  // Random write-port backpressure while enabled
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_ready_en) wr_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int            bd_before;
    logic [TW-1:0] d;
    logic [DW-1:0] v;

    clear_model();
    reset         = 1'b1;
    wr_ready      = 1'b0;
    data_in.valid = 1'b0;
    data_in.dest  = '0;
    data_in.data  = '0;
    cycles(3);

    // Reset values
    check("rst_wr_valid", 128'(wr_valid), 128'(0));
    check("rst_ready", 128'(data_in.ready), 128'(1));
    check("rst_wr_addr", 128'(wr_addr), 128'(0));
    check("rst_wr_data", 128'(wr_data), 128'(0));
    check("rst_regs", 128'(registers_out), 128'(0));
    check("rst_batch_done", 128'(batch_done), 128'(0));
    reset = 1'b0;
    cycles(2);

    // Three writes fill the bank and close one batch
    wr_ready  = 1'b1;
    bd_before = n_bd_seen;
    send_beat(8'd2, 32'hA5A5A5A5);
    send_beat(8'd1, 32'h12345678);
    send_beat(8'd0, 32'hDEADBEEF);
    drain();
    check("t1_regs", 128'(registers_out), 128'({32'hA5A5A5A5, 32'h12345678, 32'hDEADBEEF}));
    check("t1_batch_pulses", 128'(n_bd_seen - bd_before), 128'(1));

    // Single beat latency: wr_valid high for exactly the cycle after acceptance
    send_beat(8'd1, 32'h0000CAFE);
    check("t2_valid_next", 128'(wr_valid), 128'(1));
    cycles(1);
    check("t2_valid_gone", 128'(wr_valid), 128'(0));
    drain();

    // Backpressure: 4 beats fill the FIFO, 5th is held, then all drain in order
    wr_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send_beat(TW'(i % 3), 32'h1000 + DW'(i));
      end
      begin
        cycles(14);
        check("t3_ready_full", 128'(data_in.ready), 128'(0));
        check("t3_fifth_held", 128'(data_in.valid), 128'(1));
        check("t3_head_addr", 128'(wr_addr), 128'(0));
        check("t3_head_data", 128'(wr_data), 128'(32'h1000));
        wr_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats buffered discards them immediately
    wr_ready = 1'b0;
    send_beat(8'd2, 32'h77777777);
    send_beat(8'd0, 32'h88888888);
    cycles(1);
    #2;
    reset = 1'b1;
    clear_model();
    #1;
    check("t6_wr_valid", 128'(wr_valid), 128'(0));
    check("t6_ready", 128'(data_in.ready), 128'(1));
    check("t6_regs", 128'(registers_out), 128'(0));
    cycles(2);
    reset    = 1'b0;
    wr_ready = 1'b1;
    cycles(3);
    check("t6_no_stale", 128'(wr_valid), 128'(0));
    bd_before = n_bd_seen;
    send_beat(8'd0, 32'h01010101);
    send_beat(8'd1, 32'h02020202);
    send_beat(8'd2, 32'h03030303);
    drain();
    check("t6_fresh_batch", 128'(n_bd_seen - bd_before), 128'(1));

    // Out-of-range dest followed by a valid beat
    send_beat(8'd7, 32'h0BADF00D);
    send_beat(8'd1, 32'h55AA55AA);
    drain();
    check("t7_reg1", 128'(registers_out[DW +: DW]), 128'(32'h55AA55AA));
`ifdef AXIS_REGISTER_WRITER_RANGE_CHECK_EN
    check("t7_range_error", 128'(range_error), 128'(1));
`endif

    // Random phase with random backpressure and gaps
    rand_ready_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) d = TW'($urandom_range(0, 255));
      else d = TW'($urandom_range(0, NREG - 1));
      v = DW'($urandom);
      send_beat(d, v);
      if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 3));
    end
    rand_ready_en = 1'b0;
    cycles(1);
    wr_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
